// File: rtl/mod12_pkg.sv
// Shared types and constants for the MOD-12 sequencing controller and its counter.
package mod12_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int DEF_MOD = 12;
  localparam int DEF_CW  = 4;
  localparam int CNT_MAX = DEF_MOD - 1;

endpackage

// File: rtl/mod12_seq_cnt.sv
// Loadable modulo-MOD up counter; wrap is a registered pulse aligned with the MOD-1 -> 0 step.
module mod12_seq_cnt
  import mod12_pkg::*;
#(
  parameter int MOD = DEF_MOD,
  parameter int CW  = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          en,
  input  logic [CW-1:0] d,
  output logic [CW-1:0] q,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  logic [CW-1:0] q_d;
  logic          wrap_d;

  always_comb begin
    q_d    = q;
    wrap_d = 1'b0;
    if (ld) begin
      q_d = d;
    end else if (en) begin
      if (q == LAST) begin
        q_d    = '0;
        wrap_d = 1'b1;
      end else begin
        q_d = q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_d;
      wrap <= wrap_d;
    end
  end

endmodule

// File: rtl/mod12_seq_ctrl.sv
// Sequencing controller: captures a start command, drives the counter's load/enable,
// counts laps and reports done/err with registered outputs.
module mod12_seq_ctrl
  import mod12_pkg::*;
#(
  parameter int MOD = DEF_MOD,
  parameter int CW  = DEF_CW,
  parameter int LW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          hold,
  input  logic          tick,
  input  logic [CW-1:0] init_val,
  input  logic [LW-1:0] laps,
  input  logic          auto_reload,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [CW:0]   MOD_V = (CW+1)'(MOD);
  localparam logic [CW-1:0] LAST  = CW'(MOD - 1);

  state_e        state_q;
  logic [CW-1:0] init_cap_q;
  logic [LW-1:0] laps_cap_q;
  logic [LW-1:0] lap_cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          cnt_ld;
  logic          cnt_en;
  logic [CW-1:0] cnt_d;
  logic          start_ok;
  logic          bad_cnt;
  logic          wrap_evt;
  logic          lap_hit;

  assign start_ok = start && ({1'b0, init_val} < MOD_V);
  // An out-of-range count in RUN is cleared through the load path so no wrap is reported.
  assign bad_cnt  = {1'b0, count} >= MOD_V;
  assign wrap_evt = (state_q == S_RUN) && !abort && !hold && tick && !bad_cnt && (count == LAST);
  assign lap_hit  = (laps_cap_q != '0) && (lap_cnt_q == laps_cap_q - LW'(1));

  always_comb begin
    cnt_ld = 1'b0;
    cnt_en = 1'b0;
    cnt_d  = '0;
    case (state_q)
      S_LOAD: begin
        cnt_ld = 1'b1;
        cnt_d  = abort ? '0 : init_cap_q;
      end
      S_RUN: begin
        if (abort || bad_cnt) cnt_ld = 1'b1;
        else if (!hold && tick) cnt_en = 1'b1;
      end
      S_HOLD:  cnt_ld = abort;
      default: ;
    endcase
  end

  mod12_seq_cnt #(.MOD(MOD), .CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .ld   (cnt_ld),
    .en   (cnt_en),
    .d    (cnt_d),
    .q    (count),
    .wrap (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      init_cap_q <= '0;
      laps_cap_q <= '0;
      lap_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            init_cap_q <= init_val;
            laps_cap_q <= laps;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        S_LOAD: begin
          lap_cnt_q <= '0;
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            lap_cnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else if (hold) begin
            state_q <= S_HOLD;
          end else if (wrap_evt) begin
            if (lap_cnt_q != '1) lap_cnt_q <= lap_cnt_q + LW'(1);
            if (lap_hit) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_HOLD: begin
          if (abort) begin
            lap_cnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else if (!hold) begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          if (abort || !auto_reload) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_LOAD;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mod12_seq_ctrl.sv
// Scoreboard bench for mod12_seq_ctrl: expected outputs are queued per driven cycle
// and compared one time unit after the following rising edge.
module tb_mod12_seq_ctrl;
  import mod12_pkg::*;

  localparam int CW = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, hold, tick, auto_reload;
  logic [CW-1:0] init_val;
  logic [LW-1:0] laps;
  logic [CW-1:0] count;
  logic          wrap, busy, done, err;

  always #5 clk = ~clk;

  mod12_seq_ctrl #(.MOD(CNT_MAX + 1), .CW(CW), .LW(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .hold        (hold),
    .tick        (tick),
    .init_val    (init_val),
    .laps        (laps),
    .auto_reload (auto_reload),
    .count       (count),
    .wrap        (wrap),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic          w;
    logic          b;
    logic          d;
    logic          e;
  } exp_t;

  exp_t  sb[$];
  int    errs   = 0;
  int    checks = 0;
  int    cyc_n  = 0;
  string tag    = "init";

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", t, got, exp);
    end
  endtask

  // Queue the outputs expected after the coming rising edge, then move to the next falling edge.
  task automatic cyc(input int c, input logic w, input logic b, input logic d, input logic e);
    exp_t x;
    x.c = CW'(c);
    x.w = w;
    x.b = b;
    x.d = d;
    x.e = e;
    sb.push_back(x);
    @(negedge clk);
  endtask

  always @(posedge clk) begin : mon
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      cyc_n++;
      chk($sformatf("%s[%0d].count", tag, cyc_n), count, x.c);
      chk($sformatf("%s[%0d].wrap",  tag, cyc_n), wrap,  x.w);
      chk($sformatf("%s[%0d].busy",  tag, cyc_n), busy,  x.b);
      chk($sformatf("%s[%0d].done",  tag, cyc_n), done,  x.d);
      chk($sformatf("%s[%0d].err",   tag, cyc_n), err,   x.e);
    end
  end

  task automatic new_tag(input string t);
    tag   = t;
    cyc_n = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; tick = 1'b0;
    auto_reload = 1'b0; init_val = '0; laps = '0;
    repeat (2) @(negedge clk);
    chk("reset.count", count, 0);
    chk("reset.busy",  busy,  0);
    chk("reset.done",  done,  0);
    chk("reset.wrap",  wrap,  0);
    chk("reset.err",   err,   0);
    rst = 1'b0;
    @(negedge clk);

    new_tag("lap1");
    start = 1; init_val = 9; laps = 1; tick = 1;
    cyc(0, 0, 1, 0, 0);
    start = 0;
    cyc(9, 0, 1, 0, 0);
    cyc(10, 0, 1, 0, 0);
    cyc(11, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    new_tag("err");
    tick = 0; start = 1; init_val = 13;
    cyc(0, 0, 0, 0, 1);
    start = 0;
    cyc(0, 0, 0, 0, 0);
    start = 1; init_val = 12;
    cyc(0, 0, 0, 0, 1);
    start = 0;
    cyc(0, 0, 0, 0, 0);

    new_tag("edge11");
    start = 1; init_val = 11; laps = 1; tick = 1;
    cyc(0, 0, 1, 0, 0);
    start = 0;
    cyc(11, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);

    new_tag("ldabort");
    start = 1; init_val = 4;
    cyc(0, 0, 1, 0, 0);
    start = 0; abort = 1;
    cyc(0, 0, 0, 0, 0);
    abort = 0;
    cyc(0, 0, 0, 0, 0);

    new_tag("hold");
    start = 1; init_val = 10; laps = 2; tick = 1;
    cyc(0, 0, 1, 0, 0);
    start = 0;
    cyc(10, 0, 1, 0, 0);
    cyc(11, 0, 1, 0, 0);
    hold = 1;
    repeat (3) cyc(11, 0, 1, 0, 0);
    hold = 0;
    cyc(11, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    for (int k = 1; k <= CNT_MAX; k++) cyc(k, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);

    new_tag("reload");
    auto_reload = 1; start = 1; init_val = 3; laps = 1; tick = 1;
    cyc(0, 0, 1, 0, 0);
    start = 0;
    for (int k = 3; k <= CNT_MAX; k++) cyc(k, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    start = 1; init_val = 7; laps = 5;
    cyc(3, 0, 1, 0, 0);
    for (int k = 4; k <= 10; k++) cyc(k, 0, 1, 0, 0);
    start = 0;
    cyc(11, 0, 1, 0, 0);
    auto_reload = 0;
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);

    new_tag("abort");
    start = 1; init_val = 0; laps = 0; tick = 1;
    cyc(0, 0, 1, 0, 0);
    start = 0;
    for (int k = 0; k <= 5; k++) cyc(k, 0, 1, 0, 0);
    abort = 1; hold = 1;
    cyc(0, 0, 0, 0, 0);
    abort = 0; hold = 0;
    cyc(0, 0, 0, 0, 0);

    new_tag("freerun");
    start = 1; init_val = 0; laps = 0; tick = 1;
    cyc(0, 0, 1, 0, 0);
    start = 0;
    cyc(0, 0, 1, 0, 0);
    for (int k = 1; k <= 30; k++) cyc(k % (CNT_MAX + 1), (k % (CNT_MAX + 1)) == 0, 1, 0, 0);
    abort = 1;
    cyc(0, 0, 0, 0, 0);
    abort = 0; tick = 0;

    new_tag("midrst");
    start = 1; init_val = 7; laps = 0;
    cyc(0, 0, 1, 0, 0);
    start = 0;
    cyc(7, 0, 1, 0, 0);
    cyc(7, 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst.async.count", count, 0);
    chk("midrst.async.busy",  busy,  0);
    chk("midrst.async.wrap",  wrap,  0);
    chk("midrst.async.done",  done,  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1; init_val = 2; laps = 1;
    cyc(0, 0, 1, 0, 0);
    start = 0;
    cyc(2, 0, 1, 0, 0);
    abort = 1;
    cyc(0, 0, 0, 0, 0);
    abort = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
